change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream consumer of the payment state machine's 3-bit `state` output.
- On the payment decision it computes the amount owed back to the user:
  - valid note: inserted − price;
  - invalid note or insufficient payment: full refund.
- Pays that amount out one coin at a time to the coin ejector over a valid/ack handshake, using greedy denominations 10, 5, 2, 1.
- Runs independently, because the payment FSM leaves its dispense state after one cycle.

Parameters:
- W, 5, width of money values (input_money, value_to_pay, change_total, coin_value).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; returns block to IDLE.
- main_state  input  3  payment FSM state; 3'b011 = valid money, 3'b010 = invalid money.
- input_money  input  W  inserted amount, stable while main_state is 010/011.
- value_to_pay  input  W  product price.
- dispense_ack  input  1  ejector accepted current coin.
- coin_valid  output  1  coin_value holds a coin to eject.
- coin_value  output  W  denomination being ejected: 10, 5, 2 or 1.
- busy  output  1  high from capture until done.
- done  output  1  one-cycle pulse when payout is complete.
- refund  output  1  latched at capture: 1 = full refund (invalid or insufficient).
- change_total  output  W  amount latched at capture, held until next capture.
- overrun  output  1  one-cycle pulse: capture condition seen while busy.

Behaviour:
- All outputs are registered.
- Reset values: coin_valid=0, coin_value=0, busy=0, done=0, refund=0, change_total=0, overrun=0, state=IDLE, remaining=0.
- Reset is asynchronous; mid-operation it drops coin_valid immediately and the pending coin is abandoned.
- Capture condition: main_state==3'b011 or 3'b010, sampled at a rising edge while in IDLE.
- Amount at capture:
  - 3'b010: amount = input_money, refund=1.
  - 3'b011 and input_money ≥ value_to_pay: amount = input_money − value_to_pay, refund=0.
  - 3'b011 and input_money < value_to_pay: amount = input_money, refund=1.
  - Subtraction is unsigned W-bit and is only performed when it cannot underflow.
- On capture: remaining ← amount, change_total ← amount, busy ← 1, go SELECT.
- FSM states: IDLE, SELECT, ISSUE, DONE.
  - IDLE: wait for the capture condition. Other main_state values are ignored.
  - SELECT:
    - remaining==0 → go DONE.
    - Otherwise coin_value ← largest of {10,5,2,1} ≤ remaining; coin_valid ← 1; go ISSUE.
  - ISSUE:
    - coin_valid and coin_value are held stable until dispense_ack is sampled high.
    - On that edge: remaining ← remaining − coin_value, coin_valid ← 0, go SELECT.
    - dispense_ack while not in ISSUE is ignored.
  - DONE: done ← 1 for exactly one cycle, busy ← 0, go IDLE. change_total and refund keep their values.
- Latency:
  - Capture edge → coin_valid high after the next edge (SELECT).
  - With ack tied high, each coin takes 2 cycles: ISSUE, then SELECT.
  - Zero change: capture → SELECT → DONE; done asserts 2 edges after capture, no coins issued.
- Capture condition while busy (any state other than IDLE):
  - Ignored; remaining, change_total and refund are unchanged.
  - overrun pulses for 1 cycle per edge at which it is seen.
  - Because the payment FSM holds 010/011 for one cycle, this indicates a back-to-back transaction.
- Capture in the same cycle as done: DONE always returns to IDLE, so that capture is missed and flagged via overrun. The capture must be re-presented after IDLE.
- Maximum amount is 31 (W=5). The greedy sequence always terminates because a 1-coin is always available.

Test Plan:
- Money 30, price 17 (state 011), ack tied high → refund=0, change_total=13; coins 10, 2, 1, each coin_valid for 1 cycle; done pulses once; busy low afterwards.
- Money 7, state 010 → refund=1, change_total=7; coins 5, 2; done pulses.
- Money 20, price 20 (state 011) → change_total=0; coin_valid never rises; done asserts 2 edges after capture.
- Money 10, price 25 (state 011) → refund=1, change_total=10; single coin 10.
- Money 30, price 4, ack withheld 5 cycles on the first coin → coin_value=10 and coin_valid held stable all 5 cycles; then coins 10, 5, 1.
- Assert reset while coin_valid=1 mid-payout → coin_valid, busy and change_total are 0 before the next edge. Separately, present state 011 while busy → overrun pulses once and the in-flight payout completes unchanged.

Source files
------------

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout of change/refund after the payment decision
module change_dispenser #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [2:0]   main_state,
    input  logic [W-1:0] input_money,
    input  logic [W-1:0] value_to_pay,
    input  logic         dispense_ack,
    output logic         coin_valid,
    output logic [W-1:0] coin_value,
    output logic         busy,
    output logic         done,
    output logic         refund,
    output logic [W-1:0] change_total,
    output logic         overrun
);

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

    localparam logic [W-1:0] COIN_10 = W'(10);
    localparam logic [W-1:0] COIN_5  = W'(5);
    localparam logic [W-1:0] COIN_2  = W'(2);
    localparam logic [W-1:0] COIN_1  = W'(1);

    state_t       state, state_n;
    logic [W-1:0] remaining, remaining_n;
    logic [W-1:0] coin_value_n, change_total_n;
    logic         coin_valid_n, busy_n, done_n, refund_n, overrun_n;

    logic         capture;
    logic [W-1:0] amount;
    logic         amount_refund;
    logic [W-1:0] pick;

    assign capture = (main_state == 3'b011) || (main_state == 3'b010);

    // Subtract only when the note is valid and covers the price, so no underflow.
    always_comb begin
        amount        = input_money;
        amount_refund = 1'b1;
        if (main_state == 3'b011 && input_money >= value_to_pay) begin
            amount        = input_money - value_to_pay;
            amount_refund = 1'b0;
        end
    end

    always_comb begin
        if (remaining >= COIN_10)     pick = COIN_10;
        else if (remaining >= COIN_5) pick = COIN_5;
        else if (remaining >= COIN_2) pick = COIN_2;
        else                          pick = COIN_1;
    end

    always_comb begin
        state_n        = state;
        remaining_n    = remaining;
        coin_valid_n   = coin_valid;
        coin_value_n   = coin_value;
        busy_n         = busy;
        done_n         = 1'b0;
        refund_n       = refund;
        change_total_n = change_total;
        overrun_n      = 1'b0;

        if (state != IDLE && capture) overrun_n = 1'b1;

        case (state)
            IDLE: begin
                if (capture) begin
                    remaining_n    = amount;
                    change_total_n = amount;
                    refund_n       = amount_refund;
                    busy_n         = 1'b1;
                    state_n        = SELECT;
                end
            end
            SELECT: begin
                if (remaining == '0) begin
                    state_n = DONE;
                end else begin
                    coin_value_n = pick;
                    coin_valid_n = 1'b1;
                    state_n      = ISSUE;
                end
            end
            ISSUE: begin
                if (dispense_ack) begin
                    remaining_n  = remaining - coin_value;
                    coin_valid_n = 1'b0;
                    state_n      = SELECT;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            coin_valid   <= 1'b0;
            coin_value   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            refund       <= 1'b0;
            change_total <= '0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_n;
            remaining    <= remaining_n;
            coin_valid   <= coin_valid_n;
            coin_value   <= coin_value_n;
            busy         <= busy_n;
            done         <= done_n;
            refund       <= refund_n;
            change_total <= change_total_n;
            overrun      <= overrun_n;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    localparam int W = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   main_state;
    logic [W-1:0] input_money;
    logic [W-1:0] value_to_pay;
    logic         dispense_ack;
    logic         coin_valid;
    logic [W-1:0] coin_value;
    logic         busy;
    logic         done;
    logic         refund;
    logic [W-1:0] change_total;
    logic         overrun;

    int checks = 0;
    int errors = 0;
    int coins[$];
    int done_count = 0;
    int valid_cycles = 0;
    int coin_base, done_base, valid_base;

    change_dispenser #(.W(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .main_state  (main_state),
        .input_money (input_money),
        .value_to_pay(value_to_pay),
        .dispense_ack(dispense_ack),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .busy        (busy),
        .done        (done),
        .refund      (refund),
        .change_total(change_total),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    // Record what the ejector actually accepts, exactly as the DUT samples it.
    always @(posedge clock) begin
        if (coin_valid && dispense_ack) coins.push_back(int'(coin_value));
        if (coin_valid) valid_cycles++;
        if (done) done_count++;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [2:0] st, input int m, input int p);
        @(negedge clock);
        main_state   = st;
        input_money  = W'(m);
        value_to_pay = W'(p);
        coin_base    = coins.size();
        done_base    = done_count;
        valid_base   = valid_cycles;
        @(negedge clock);
        main_state   = 3'b000;
    endtask

    task automatic wait_done(input string tag, input int exp_edges);
        int e = 0;
        while (!done && e < 100) begin
            @(negedge clock);
            e++;
        end
        check_eq({tag, "_done_seen"}, int'(done), 1);
        if (exp_edges >= 0) check_eq({tag, "_done_latency"}, e, exp_edges);
        check_eq({tag, "_busy_at_done"}, int'(busy), 0);
        @(negedge clock);
        check_eq({tag, "_done_pulse_end"}, int'(done), 0);
        check_eq({tag, "_done_count"}, done_count - done_base, 1);
    endtask

    task automatic check_coins(input string tag, input int n,
                               input int c0, input int c1, input int c2, input int c3);
        int exp[4];
        int got;
        exp = '{c0, c1, c2, c3};
        got = coins.size() - coin_base;
        check_eq({tag, "_coin_count"}, got, n);
        for (int i = 0; i < n && i < got; i++)
            check_eq($sformatf("%s_coin%0d", tag, i), coins[coin_base + i], exp[i]);
    endtask

    initial begin
        reset        = 1'b1;
        main_state   = 3'b000;
        input_money  = '0;
        value_to_pay = '0;
        dispense_ack = 1'b1;
        #1;
        check_eq("rst_coin_valid", int'(coin_valid), 0);
        check_eq("rst_coin_value", int'(coin_value), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_refund", int'(refund), 0);
        check_eq("rst_change_total", int'(change_total), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        @(negedge clock);
        reset = 1'b0;

        // 30 - 17 = 13 -> 10, 2, 1
        start(3'b011, 30, 17);
        check_eq("t1_busy", int'(busy), 1);
        check_eq("t1_refund", int'(refund), 0);
        check_eq("t1_change_total", int'(change_total), 13);
        check_eq("t1_no_coin_yet", int'(coin_valid), 0);
        wait_done("t1", 8);
        check_coins("t1", 3, 10, 2, 1, 0);
        check_eq("t1_valid_cycles", valid_cycles - valid_base, 3);

        // invalid note 7 -> full refund 5, 2
        start(3'b010, 7, 3);
        check_eq("t2_refund", int'(refund), 1);
        check_eq("t2_change_total", int'(change_total), 7);
        wait_done("t2", 6);
        check_coins("t2", 2, 5, 2, 0, 0);

        // exact payment: no coins
        start(3'b011, 20, 20);
        check_eq("t3_refund", int'(refund), 0);
        check_eq("t3_change_total", int'(change_total), 0);
        wait_done("t3", 2);
        check_coins("t3", 0, 0, 0, 0, 0);
        check_eq("t3_valid_cycles", valid_cycles - valid_base, 0);

        // insufficient payment: refund 10
        start(3'b011, 10, 25);
        check_eq("t4_refund", int'(refund), 1);
        check_eq("t4_change_total", int'(change_total), 10);
        wait_done("t4", 4);
        check_coins("t4", 1, 10, 0, 0, 0);

        // ack withheld for 5 cycles on the first coin; 26 -> 10, 10, 5, 1
        dispense_ack = 1'b0;
        start(3'b011, 30, 4);
        check_eq("t5_change_total", int'(change_total), 26);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t5_hold_valid%0d", i), int'(coin_valid), 1);
            check_eq($sformatf("t5_hold_value%0d", i), int'(coin_value), 10);
            if (i < 4) @(negedge clock);
        end
        dispense_ack = 1'b1;
        wait_done("t5", -1);
        check_coins("t5", 4, 10, 10, 5, 1);

        // asynchronous reset while a coin is pending
        dispense_ack = 1'b0;
        start(3'b011, 30, 4);
        @(negedge clock);
        check_eq("t6_pre_valid", int'(coin_valid), 1);
        #1 reset = 1'b1;
        #1;
        check_eq("t6_rst_valid", int'(coin_valid), 0);
        check_eq("t6_rst_busy", int'(busy), 0);
        check_eq("t6_rst_change_total", int'(change_total), 0);
        @(negedge clock);
        reset        = 1'b0;
        dispense_ack = 1'b1;

        // capture presented while busy -> overrun, payout unaffected
        start(3'b011, 30, 17);
        @(negedge clock);
        main_state   = 3'b011;
        input_money  = W'(31);
        value_to_pay = W'(1);
        @(negedge clock);
        main_state = 3'b000;
        check_eq("t7_overrun_pulse", int'(overrun), 1);
        check_eq("t7_change_kept", int'(change_total), 13);
        check_eq("t7_refund_kept", int'(refund), 0);
        @(negedge clock);
        check_eq("t7_overrun_end", int'(overrun), 0);
        wait_done("t7", -1);
        check_coins("t7", 3, 10, 2, 1, 0);
        check_eq("t7_change_final", int'(change_total), 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
